// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - synchroniser plus consecutive-sample debouncer with rise/fall pulses
//
// Purpose: brings an asynchronous level input into the clk domain through a
// SYNC_STAGES flop chain and only accepts a change of level once the synced
// value has differed from the current level for DEBOUNCE_CYCLES consecutive
// samples. A one-cycle rise or fall pulse accompanies every accepted change.
//
// Optional feature macro: DEBOUNCE_EVT_CNT_EN adds the EVT_W parameter and the
// evt_cnt output, a wrapping count of accepted rising changes.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   async_in   in   1      raw asynchronous input
//   level_out  out  1      debounced level
//   rise_pulse out  1      high for the first cycle level_out shows 1 after 0
//   fall_pulse out  1      high for the first cycle level_out shows 0 after 1
//   evt_cnt    out  EVT_W  rise-event count (DEBOUNCE_EVT_CNT_EN only)
module sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RESET_LEVEL     = 0
`ifdef DEBOUNCE_EVT_CNT_EN
    ,
    parameter int EVT_W           = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             async_in,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse
`ifdef DEBOUNCE_EVT_CNT_EN
    ,
    output logic [EVT_W-1:0] evt_cnt
`endif
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic             RST_LVL  = (RESET_LEVEL != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_e;

    localparam state_e RST_STATE = RST_LVL ? STABLE_HI : STABLE_LO;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_out;
    logic                   differ;

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign differ   = (sync_out != level_q);

    // Shift toward the MSB; the MSB is the fully synchronised sample.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], async_in};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LO, STABLE_HI: begin
                if (differ) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        // A single differing sample is already enough.
                        level_d = sync_out;
                        state_d = sync_out ? STABLE_HI : STABLE_LO;
                        rise_d  = sync_out;
                        fall_d  = ~sync_out;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = (state_q == STABLE_LO) ? PEND_HI : PEND_LO;
                    end
                end
            end
            PEND_HI, PEND_LO: begin
                if (!differ) begin
                    // Bounce: drop the partial count, keep the old level.
                    cnt_d   = '0;
                    state_d = (state_q == PEND_HI) ? STABLE_LO : STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    level_d = ~level_q;
                    state_d = (state_q == PEND_HI) ? STABLE_HI : STABLE_LO;
                    rise_d  = (state_q == PEND_HI);
                    fall_d  = (state_q == PEND_LO);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                level_d = RST_LVL;
                state_d = RST_STATE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= {SYNC_STAGES{RST_LVL}};
            state_q <= RST_STATE;
            cnt_q   <= '0;
            level_q <= RST_LVL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef DEBOUNCE_EVT_CNT_EN
    logic [EVT_W-1:0] evt_q, evt_d;

    // Counts on the same edge that launches rise_pulse; wraps naturally.
    assign evt_d = rise_d ? (evt_q + EVT_W'(1)) : evt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_q <= '0;
        end else begin
            evt_q <= evt_d;
        end
    end

    assign evt_cnt = evt_q;
`endif

endmodule
